odometer_meas_sequencer: RTL and testbench
==========================================

Name: odometer_meas_sequencer

Overview:
- Sequences a bank of N_ODO stacked odometer instances through configure, stress, measure and read-out phases on one CLK.
- Drives the shared LOAD/SEL_INV*/AC_DC/START configuration and one MEAS_TRIG per instance.
- Captures every instance's 12-bit BF_COUNT after each measurement window.
- Streams the results one at a time over a valid/ready port to the chip-level scan/readout logic.

Parameters:
- N_ODO, 4, number of odometer instances sequenced.
- CNT_W, 12, BF_COUNT width per instance.
- MEAS_WIN, 1024, cycles MEAS_TRIG is held high per measurement.
- SETTLE, 8, cycles between MEAS_TRIG fall and BF_COUNT capture.

Ports:
- CLK  in  1  sequencer clock.
- RESETB  in  1  synchronous active-low reset.
- GO  in  1  start a run; sampled only in IDLE.
- ABORT  in  1  terminate the run.
- CFG_SEL  in  3  {INV97,INV101,INV99} ring-length select, sampled on GO.
- CFG_AC_DC  in  1  stress mode, sampled on GO.
- CFG_STRESS_CYC  in  24  stress cycles per interval, sampled on GO.
- CFG_NUM_MEAS  in  8  measurements per run; 0 = continuous.
- LOAD  out  1  config latch pulse to the odometers.
- SEL_INV99 / SEL_INV101 / SEL_INV97  out  1 each  latched CFG_SEL bits.
- AC_DC  out  1  latched CFG_AC_DC.
- START  out  1  stress oscillator enable.
- MEAS_TRIG  out  N_ODO  per-instance measure trigger.
- BF_COUNT_IN  in  N_ODO*CNT_W  instance i occupies bits [i*CNT_W +: CNT_W].
- RES_VALID  out  1  result available.
- RES_READY  in  1  consumer accepts the result.
- RES_DATA  out  CNT_W  captured count.
- RES_ID  out  clog2(N_ODO)  instance index.
- RES_SEQ  out  8  measurement index, wraps at 255->0.
- BUSY  out  1  high whenever state != IDLE.
- DONE  out  1  one-cycle pulse on normal completion.

Behaviour:
- Reset (RESETB=0 at a CLK edge): state=IDLE; all outputs 0; counters and the capture buffer cleared. Reset overrides GO and ABORT.
- States: IDLE, LOADC, STRESS, MEAS, SETTLE, CAPT, DRAIN, FIN.
- IDLE:
  - GO=1 with ABORT=0 latches CFG_* and goes to LOADC next cycle.
  - Simultaneous GO and ABORT: stay in IDLE.
  - GO while BUSY is ignored.
- LOADC (1 cycle): LOAD=1. SEL_INV*/AC_DC come from the latched config from this cycle on and hold those values until the next GO, including in IDLE. Next state is STRESS.
- STRESS:
  - START=1 from entry, held through STRESS, MEAS, SETTLE, CAPT and DRAIN.
  - Lasts exactly CFG_STRESS_CYC cycles; a value of 0 is treated as 1.
  - Next state is MEAS.
- MEAS: MEAS_TRIG = all ones for exactly MEAS_WIN cycles, then SETTLE.
- SETTLE: MEAS_TRIG = 0 for SETTLE cycles, then CAPT.
- CAPT (1 cycle): register all N_ODO BF_COUNT_IN slices, then DRAIN.
- DRAIN:
  - Presents instances 0..N_ODO-1 in order with RES_SEQ = current measurement index.
  - RES_VALID stays high and RES_DATA/RES_ID/RES_SEQ stay stable until RES_READY=1.
  - A transfer occurs on a cycle with RES_VALID&&RES_READY. The next result is presented the following cycle, so there is no bubble when RES_READY is held high.
  - After the last transfer, increment the measurement index. If CFG_NUM_MEAS!=0 and the index equals CFG_NUM_MEAS, go to FIN; otherwise go to STRESS.
  - Backpressure time is extra stress; the stress counter restarts on STRESS entry.
- FIN (1 cycle): START=0, DONE=1, next state IDLE.
- ABORT=1 in any non-IDLE state: next cycle is IDLE with START, MEAS_TRIG, LOAD, RES_VALID = 0. DONE stays 0 and undrained results are discarded.
- BUSY=1 in every state except IDLE.
- Continuous mode (CFG_NUM_MEAS=0): runs until ABORT or reset; RES_SEQ wraps 255->0.

Test Plan:
- Reset, then GO with CFG_SEL=3'b001, CFG_AC_DC=1, CFG_STRESS_CYC=10, CFG_NUM_MEAS=1, RES_READY=1, MEAS_WIN=16, SETTLE=2:
  - LOAD high 1 cycle; SEL_INV99=1, AC_DC=1.
  - START rises the next cycle; MEAS_TRIG=4'hF exactly 16 cycles after 10 stress cycles.
  - 4 results RES_ID 0..3 on consecutive cycles; DONE pulse; START=0.
- BF_COUNT_IN slices = 12'h123, 12'hABC, 12'hFFF, 12'h000 -> RES_DATA matches per RES_ID; RES_SEQ=0.
- RES_READY low 5 cycles on result 2 -> RES_VALID/RES_DATA/RES_ID held stable; no loss or duplication; DONE only after 4 transfers.
- CFG_NUM_MEAS=3 -> three MEAS windows, 12 results with RES_SEQ 0,0,0,0,1,...,2; single DONE.
- ABORT mid-MEAS -> next cycle MEAS_TRIG=0, START=0, BUSY=0, DONE=0. A later GO restarts cleanly with RES_SEQ=0.
- CFG_STRESS_CYC=0 gives a 1-cycle STRESS. GO with ABORT in IDLE -> stays IDLE. GO during STRESS is ignored. RESETB low mid-DRAIN -> all outputs 0 next cycle.

Source files
------------

// File: rtl/odometer_meas_sequencer.sv
// odometer_meas_sequencer
// Purpose: runs a bank of N_ODO stacked odometers through configure, stress,
// measure and read-out phases, then streams each instance's captured
// BF_COUNT over a valid/ready port.
// Ports:
//   CLK, RESETB            clock, synchronous active-low reset
//   GO, ABORT              start a run (idle only) / terminate a run
//   CFG_SEL, CFG_AC_DC,    run configuration, latched when GO is accepted
//   CFG_STRESS_CYC,
//   CFG_NUM_MEAS           (CFG_NUM_MEAS = 0 runs until ABORT)
//   LOAD                   one-cycle config latch pulse to the odometers
//   SEL_INV99/101/97,AC_DC latched configuration to the odometers
//   START                  stress oscillator enable
//   MEAS_TRIG              per-instance measurement trigger
//   BF_COUNT_IN            instance i count at [i*CNT_W +: CNT_W]
//   RES_VALID/READY/DATA/  result stream: count, instance index and
//   RES_ID/RES_SEQ         measurement index
//   BUSY, DONE             run in progress / normal-completion pulse
module odometer_meas_sequencer #(
   parameter  int unsigned N_ODO    = 4,
   parameter  int unsigned CNT_W    = 12,
   parameter  int unsigned MEAS_WIN = 1024,
   parameter  int unsigned SETTLE   = 8,
   localparam int unsigned ID_W     = (N_ODO > 1) ? $clog2(N_ODO) : 1
) (
   input  logic                   CLK,
   input  logic                   RESETB,
   input  logic                   GO,
   input  logic                   ABORT,
   input  logic [2:0]             CFG_SEL,
   input  logic                   CFG_AC_DC,
   input  logic [23:0]            CFG_STRESS_CYC,
   input  logic [7:0]             CFG_NUM_MEAS,
   output logic                   LOAD,
   output logic                   SEL_INV99,
   output logic                   SEL_INV101,
   output logic                   SEL_INV97,
   output logic                   AC_DC,
   output logic                   START,
   output logic [N_ODO-1:0]       MEAS_TRIG,
   input  logic [N_ODO*CNT_W-1:0] BF_COUNT_IN,
   output logic                   RES_VALID,
   input  logic                   RES_READY,
   output logic [CNT_W-1:0]       RES_DATA,
   output logic [ID_W-1:0]        RES_ID,
   output logic [7:0]             RES_SEQ,
   output logic                   BUSY,
   output logic                   DONE
);

   localparam int unsigned TMR_W = 24;

   typedef enum logic [2:0] {
      S_IDLE, S_LOADC, S_STRESS, S_MEAS, S_SETTLE, S_CAPT, S_DRAIN, S_FIN
   } state_t;

   state_t             state;
   logic [23:0]        stress_cyc;
   logic [7:0]         num_meas;
   logic [7:0]         meas_idx;
   logic [TMR_W-1:0]   tmr;
   logic [CNT_W-1:0]   cap [N_ODO];
   logic [TMR_W-1:0]   stress_last_c;
   logic [7:0]         meas_next_c;

   // A programmed stress length of 0 still gives one STRESS cycle.
   always_comb begin
      stress_last_c = '0;
      if (stress_cyc != '0) stress_last_c = stress_cyc - TMR_W'(1);
      meas_next_c = meas_idx + 8'd1;
   end

   // Sequencer: state, phase timer, capture buffer and registered outputs.
   always_ff @(posedge CLK) begin
      if (!RESETB) begin
         state      <= S_IDLE;
         stress_cyc <= '0;
         num_meas   <= '0;
         meas_idx   <= '0;
         tmr        <= '0;
         for (int i = 0; i < int'(N_ODO); i++) cap[i] <= '0;
         LOAD       <= 1'b0;
         SEL_INV99  <= 1'b0;
         SEL_INV101 <= 1'b0;
         SEL_INV97  <= 1'b0;
         AC_DC      <= 1'b0;
         START      <= 1'b0;
         MEAS_TRIG  <= '0;
         RES_VALID  <= 1'b0;
         RES_DATA   <= '0;
         RES_ID     <= '0;
         RES_SEQ    <= '0;
         BUSY       <= 1'b0;
         DONE       <= 1'b0;
      end else begin
         LOAD <= 1'b0;
         DONE <= 1'b0;
         if (state != S_IDLE && ABORT) begin
            // Abort drops everything in flight; configuration outputs persist.
            state     <= S_IDLE;
            START     <= 1'b0;
            MEAS_TRIG <= '0;
            RES_VALID <= 1'b0;
            BUSY      <= 1'b0;
         end else begin
            case (state)
               S_IDLE: begin
                  if (GO && !ABORT) begin
                     state      <= S_LOADC;
                     BUSY       <= 1'b1;
                     LOAD       <= 1'b1;
                     SEL_INV99  <= CFG_SEL[0];
                     SEL_INV101 <= CFG_SEL[1];
                     SEL_INV97  <= CFG_SEL[2];
                     AC_DC      <= CFG_AC_DC;
                     stress_cyc <= CFG_STRESS_CYC;
                     num_meas   <= CFG_NUM_MEAS;
                     meas_idx   <= '0;
                  end
               end
               S_LOADC: begin
                  state <= S_STRESS;
                  START <= 1'b1;
                  tmr   <= '0;
               end
               S_STRESS: begin
                  if (tmr == stress_last_c) begin
                     state     <= S_MEAS;
                     MEAS_TRIG <= '1;
                     tmr       <= '0;
                  end else begin
                     tmr <= tmr + TMR_W'(1);
                  end
               end
               S_MEAS: begin
                  if (tmr == TMR_W'(MEAS_WIN - 1)) begin
                     state     <= S_SETTLE;
                     MEAS_TRIG <= '0;
                     tmr       <= '0;
                  end else begin
                     tmr <= tmr + TMR_W'(1);
                  end
               end
               S_SETTLE: begin
                  if (tmr == TMR_W'(SETTLE - 1)) state <= S_CAPT;
                  else                           tmr   <= tmr + TMR_W'(1);
               end
               S_CAPT: begin
                  // Snapshot every instance and present instance 0 at once.
                  for (int i = 0; i < int'(N_ODO); i++)
                     cap[i] <= BF_COUNT_IN[i*CNT_W +: CNT_W];
                  RES_DATA  <= BF_COUNT_IN[CNT_W-1:0];
                  RES_ID    <= '0;
                  RES_SEQ   <= meas_idx;
                  RES_VALID <= 1'b1;
                  state     <= S_DRAIN;
               end
               S_DRAIN: begin
                  if (RES_READY) begin
                     if (RES_ID == ID_W'(N_ODO - 1)) begin
                        RES_VALID <= 1'b0;
                        meas_idx  <= meas_next_c;
                        tmr       <= '0;
                        if (num_meas != '0 && meas_next_c == num_meas) begin
                           state <= S_FIN;
                           START <= 1'b0;
                           DONE  <= 1'b1;
                        end else begin
                           state <= S_STRESS;
                        end
                     end else begin
                        // Next result follows the transfer with no bubble.
                        RES_ID   <= RES_ID + ID_W'(1);
                        RES_DATA <= cap[RES_ID + ID_W'(1)];
                     end
                  end
               end
               S_FIN: begin
                  state <= S_IDLE;
                  BUSY  <= 1'b0;
               end
               default: begin
                  state <= S_IDLE;
                  BUSY  <= 1'b0;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_odometer_meas_sequencer.sv
// tb_odometer_meas_sequencer
// Purpose: self-checking bench for odometer_meas_sequencer. A timeline model
// (per-cycle expected slots plus a result queue) predicts every output each
// cycle; directed sequences pin the model with literal expectations, then a
// randomized phase exercises GO/ABORT/backpressure/reset interactions.
module tb_odometer_meas_sequencer;

   localparam int unsigned N  = 4;
   localparam int unsigned CW = 12;
   localparam int unsigned MW = 16;
   localparam int unsigned ST = 2;
   localparam int unsigned IW = 2;

   logic            CLK = 1'b0;
   logic            RESETB = 1'b0;
   logic            GO = 1'b0;
   logic            ABORT = 1'b0;
   logic [2:0]      CFG_SEL = '0;
   logic            CFG_AC_DC = 1'b0;
   logic [23:0]     CFG_STRESS_CYC = '0;
   logic [7:0]      CFG_NUM_MEAS = '0;
   logic            LOAD, SEL_INV99, SEL_INV101, SEL_INV97, AC_DC, START;
   logic [N-1:0]    MEAS_TRIG;
   logic [N*CW-1:0] BF_COUNT_IN = '0;
   logic            RES_VALID;
   logic            RES_READY = 1'b0;
   logic [CW-1:0]   RES_DATA;
   logic [IW-1:0]   RES_ID;
   logic [7:0]      RES_SEQ;
   logic            BUSY, DONE;

   odometer_meas_sequencer #(.N_ODO(N), .CNT_W(CW), .MEAS_WIN(MW), .SETTLE(ST)) dut (
      .CLK(CLK), .RESETB(RESETB), .GO(GO), .ABORT(ABORT), .CFG_SEL(CFG_SEL),
      .CFG_AC_DC(CFG_AC_DC), .CFG_STRESS_CYC(CFG_STRESS_CYC), .CFG_NUM_MEAS(CFG_NUM_MEAS),
      .LOAD(LOAD), .SEL_INV99(SEL_INV99), .SEL_INV101(SEL_INV101), .SEL_INV97(SEL_INV97),
      .AC_DC(AC_DC), .START(START), .MEAS_TRIG(MEAS_TRIG), .BF_COUNT_IN(BF_COUNT_IN),
      .RES_VALID(RES_VALID), .RES_READY(RES_READY), .RES_DATA(RES_DATA), .RES_ID(RES_ID),
      .RES_SEQ(RES_SEQ), .BUSY(BUSY), .DONE(DONE)
   );

   always #5 CLK = ~CLK;

   int tests = 0;
   int fails = 0;
   int xfers = 0;
   int load_cnt = 0;
   int done_cnt = 0;
   logic [7:0] seq_log [$];

   function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
      end
   endfunction

   function automatic void timeout(input string nm);
      tests++;
      fails++;
      $display("FAIL %s: timed out waiting (t=%0t)", nm, $time);
   endfunction

   // ---------------- behavioural model ----------------
   typedef struct packed {
      logic         load;
      logic         start;
      logic [N-1:0] trig;
      logic         capt;
      logic         fin;
   } slot_t;

   typedef struct packed {
      logic [CW-1:0] data;
      logic [IW-1:0] id;
      logic [7:0]    seq;
   } res_t;

   slot_t      tl [$];
   res_t       rq [$];
   slot_t      cur = '0;
   bit         m_busy = 0, m_drain = 0, m_rst = 0;
   logic [2:0] m_sel = '0;
   logic       m_acdc = 1'b0;
   logic [23:0] m_stress = '0;
   logic [7:0] m_num = '0, m_seq = '0;

   // Expected per-cycle outputs of one measurement round up to capture.
   function automatic void push_round(input bit with_load);
      slot_t s;
      int    n;
      if (with_load) begin
         s = '0; s.load = 1'b1; tl.push_back(s);
      end
      n = (m_stress == 0) ? 1 : int'(m_stress);
      s = '0; s.start = 1'b1;
      repeat (n) tl.push_back(s);
      s.trig = '1;
      repeat (MW) tl.push_back(s);
      s.trig = '0;
      repeat (ST) tl.push_back(s);
      s.capt = 1'b1;
      tl.push_back(s);
   endfunction

   function automatic void model_step();
      m_rst = 0;
      if (!RESETB) begin
         tl.delete(); rq.delete(); cur = '0;
         m_busy = 0; m_drain = 0; m_sel = '0; m_acdc = 1'b0; m_seq = '0; m_rst = 1;
      end else if (m_busy && ABORT) begin
         tl.delete(); rq.delete(); cur = '0; m_busy = 0; m_drain = 0;
      end else if (!m_busy) begin
         if (GO && !ABORT) begin
            m_busy = 1; m_sel = CFG_SEL; m_acdc = CFG_AC_DC;
            m_stress = CFG_STRESS_CYC; m_num = CFG_NUM_MEAS; m_seq = '0;
            push_round(1'b1);
            cur = tl.pop_front();
         end
      end else if (m_drain) begin
         if (RES_READY) begin
            rq.delete(0);
            if (rq.size() == 0) begin
               m_drain = 0;
               m_seq = m_seq + 8'd1;
               if (m_num != 0 && m_seq == m_num) begin
                  cur = '0; cur.fin = 1'b1;
               end else begin
                  push_round(1'b0);
                  cur = tl.pop_front();
               end
            end
         end
      end else if (cur.fin) begin
         m_busy = 0; cur = '0;
      end else if (cur.capt) begin
         for (int i = 0; i < int'(N); i++) begin
            res_t r;
            r.data = BF_COUNT_IN[i*CW +: CW];
            r.id   = IW'(i);
            r.seq  = m_seq;
            rq.push_back(r);
         end
         m_drain = 1;
         cur = '0; cur.start = 1'b1;
      end else begin
         cur = tl.pop_front();
      end
   endfunction

   function automatic void compare();
      chk("load", 32'(LOAD), 32'(cur.load));
      chk("start", 32'(START), 32'(cur.start));
      chk("meas_trig", 32'(MEAS_TRIG), 32'(cur.trig));
      chk("done", 32'(DONE), 32'(cur.fin));
      chk("busy", 32'(BUSY), 32'(m_busy));
      chk("res_valid", 32'(RES_VALID), 32'(m_drain));
      chk("sel", 32'({SEL_INV97, SEL_INV101, SEL_INV99}), 32'(m_sel));
      chk("ac_dc", 32'(AC_DC), 32'(m_acdc));
      if (m_drain) begin
         chk("res_data", 32'(RES_DATA), 32'(rq[0].data));
         chk("res_id", 32'(RES_ID), 32'(rq[0].id));
         chk("res_seq", 32'(RES_SEQ), 32'(rq[0].seq));
      end
      if (m_rst) begin
         chk("rst_res_data", 32'(RES_DATA), 32'd0);
         chk("rst_res_id", 32'(RES_ID), 32'd0);
         chk("rst_res_seq", 32'(RES_SEQ), 32'd0);
      end
   endfunction

   // Single compare process: sample pre-edge activity, advance model, check.
   always @(posedge CLK) begin
      if (RESETB && RES_VALID && RES_READY) begin
         xfers++;
         seq_log.push_back(RES_SEQ);
      end
      if (RESETB && LOAD) load_cnt++;
      if (RESETB && DONE) done_cnt++;
      model_step();
      #1;
      compare();
   end

   // ---------------- stimulus helpers ----------------
   task automatic go(input logic [2:0] sel, input logic acdc, input logic [23:0] sc,
                     input logic [7:0] nm);
      CFG_SEL = sel; CFG_AC_DC = acdc; CFG_STRESS_CYC = sc; CFG_NUM_MEAS = nm;
      GO = 1'b1;
      @(negedge CLK);
      GO = 1'b0;
   endtask

   task automatic wait_valid(input int bound);
      int n = 0;
      while (!RES_VALID && n < bound) begin n++; @(negedge CLK); end
      if (!RES_VALID) timeout("wait_valid");
   endtask

   task automatic wait_idle(input int bound);
      int n = 0;
      while (BUSY && n < bound) begin n++; @(negedge CLK); end
      if (BUSY) timeout("wait_idle");
   endtask

   task automatic count_while_stress(output int n);
      n = 0;
      while (START && MEAS_TRIG == '0 && n < 200) begin n++; @(negedge CLK); end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int n, x0, d0, l0, s0;
      logic [11:0] exp_d [4];
      exp_d[0] = 12'h123; exp_d[1] = 12'hABC; exp_d[2] = 12'hFFF; exp_d[3] = 12'h000;

      repeat (3) @(negedge CLK);
      RESETB = 1'b1;
      @(negedge CLK);

      // Basic run: literal timing and data expectations.
      BF_COUNT_IN = {12'h000, 12'hFFF, 12'hABC, 12'h123};
      RES_READY = 1'b1;
      go(3'b001, 1'b1, 24'd10, 8'd1);
      chk("t1_load", 32'(LOAD), 32'd1);
      chk("t1_sel99", 32'(SEL_INV99), 32'd1);
      chk("t1_sel101", 32'(SEL_INV101), 32'd0);
      chk("t1_acdc", 32'(AC_DC), 32'd1);
      chk("t1_start_low", 32'(START), 32'd0);
      @(negedge CLK);
      chk("t1_load_pulse", 32'(LOAD), 32'd0);
      chk("t1_start", 32'(START), 32'd1);
      count_while_stress(n);
      chk("t1_stress_len", 32'(n), 32'd10);
      chk("t1_trig", 32'(MEAS_TRIG), 32'hF);
      n = 0;
      while (MEAS_TRIG == 4'hF && n < 200) begin n++; @(negedge CLK); end
      chk("t1_trig_len", 32'(n), 32'd16);
      wait_valid(20);
      for (int i = 0; i < 4; i++) begin
         chk("t1_valid", 32'(RES_VALID), 32'd1);
         chk("t1_id", 32'(RES_ID), 32'(i));
         chk("t1_data", 32'(RES_DATA), 32'(exp_d[i]));
         chk("t1_seq", 32'(RES_SEQ), 32'd0);
         @(negedge CLK);
      end
      chk("t1_done", 32'(DONE), 32'd1);
      chk("t1_start_off", 32'(START), 32'd0);
      @(negedge CLK);
      chk("t1_idle", 32'(BUSY), 32'd0);

      // Backpressure on result 2.
      x0 = xfers; d0 = done_cnt;
      go(3'b010, 1'b0, 24'd4, 8'd1);
      n = 0;
      while (!(RES_VALID && RES_ID == 2'd2) && n < 200) begin n++; @(negedge CLK); end
      if (!(RES_VALID && RES_ID == 2'd2)) timeout("t3_wait_id2");
      RES_READY = 1'b0;
      repeat (5) begin
         @(negedge CLK);
         chk("t3_hold_valid", 32'(RES_VALID), 32'd1);
         chk("t3_hold_id", 32'(RES_ID), 32'd2);
         chk("t3_hold_data", 32'(RES_DATA), 32'hFFF);
      end
      RES_READY = 1'b1;
      wait_idle(50);
      chk("t3_xfers", 32'(xfers - x0), 32'd4);
      chk("t3_dones", 32'(done_cnt - d0), 32'd1);

      // Three measurements per run.
      x0 = xfers; d0 = done_cnt; s0 = seq_log.size();
      go(3'b100, 1'b1, 24'd3, 8'd3);
      wait_idle(500);
      chk("t4_xfers", 32'(xfers - x0), 32'd12);
      chk("t4_dones", 32'(done_cnt - d0), 32'd1);
      for (int i = 0; i < 12; i++)
         if (s0 + i < seq_log.size()) chk("t4_seq", 32'(seq_log[s0+i]), 32'(i / 4));
         else timeout("t4_seq_missing");

      // Abort mid-measurement, then restart cleanly.
      d0 = done_cnt;
      go(3'b001, 1'b0, 24'd2, 8'd2);
      n = 0;
      while (MEAS_TRIG == '0 && n < 50) begin n++; @(negedge CLK); end
      if (MEAS_TRIG == '0) timeout("t5_wait_trig");
      repeat (3) @(negedge CLK);
      ABORT = 1'b1;
      @(negedge CLK);
      ABORT = 1'b0;
      chk("t5_trig", 32'(MEAS_TRIG), 32'd0);
      chk("t5_start", 32'(START), 32'd0);
      chk("t5_busy", 32'(BUSY), 32'd0);
      chk("t5_done", 32'(DONE), 32'd0);
      @(negedge CLK);
      x0 = xfers; s0 = seq_log.size();
      go(3'b001, 1'b0, 24'd2, 8'd1);
      wait_idle(200);
      chk("t5_xfers", 32'(xfers - x0), 32'd4);
      chk("t5_dones", 32'(done_cnt - d0), 32'd1);
      if (s0 < seq_log.size()) chk("t5_seq0", 32'(seq_log[s0]), 32'd0);
      else timeout("t5_seq_missing");

      // Zero stress cycles behaves as one.
      go(3'b000, 1'b0, 24'd0, 8'd1);
      @(negedge CLK);
      count_while_stress(n);
      chk("t6_stress0", 32'(n), 32'd1);
      wait_idle(100);

      // GO together with ABORT in idle is ignored.
      GO = 1'b1; ABORT = 1'b1;
      @(negedge CLK);
      GO = 1'b0; ABORT = 1'b0;
      chk("t6_goabort_busy", 32'(BUSY), 32'd0);
      chk("t6_goabort_load", 32'(LOAD), 32'd0);

      // GO during stress is ignored.
      l0 = load_cnt; x0 = xfers; d0 = done_cnt;
      go(3'b011, 1'b1, 24'd20, 8'd1);
      repeat (5) @(negedge CLK);
      GO = 1'b1;
      @(negedge CLK);
      GO = 1'b0;
      wait_idle(300);
      chk("t6_go_busy_loads", 32'(load_cnt - l0), 32'd1);
      chk("t6_go_busy_xfers", 32'(xfers - x0), 32'd4);
      chk("t6_go_busy_dones", 32'(done_cnt - d0), 32'd1);

      // Reset in the middle of a stalled drain.
      RES_READY = 1'b0;
      go(3'b111, 1'b1, 24'd2, 8'd1);
      wait_valid(100);
      @(negedge CLK);
      RESETB = 1'b0;
      @(negedge CLK);
      chk("t6_rst_valid", 32'(RES_VALID), 32'd0);
      chk("t6_rst_start", 32'(START), 32'd0);
      chk("t6_rst_busy", 32'(BUSY), 32'd0);
      chk("t6_rst_data", 32'(RES_DATA), 32'd0);
      chk("t6_rst_sel", 32'({SEL_INV97, SEL_INV101, SEL_INV99}), 32'd0);
      chk("t6_rst_acdc", 32'(AC_DC), 32'd0);
      RESETB = 1'b1;
      RES_READY = 1'b1;
      @(negedge CLK);

      // Randomized phase: the model checks every cycle.
      for (int c = 0; c < 4000; c++) begin
         GO             = ($urandom_range(0, 19) == 0);
         ABORT          = ($urandom_range(0, 399) == 0);
         RESETB         = ($urandom_range(0, 1499) != 0);
         RES_READY      = ($urandom_range(0, 3) != 0);
         CFG_SEL        = 3'($urandom);
         CFG_AC_DC      = 1'($urandom);
         CFG_STRESS_CYC = 24'($urandom_range(0, 5));
         CFG_NUM_MEAS   = 8'($urandom_range(0, 4));
         BF_COUNT_IN    = {$urandom, $urandom};
         @(negedge CLK);
      end
      GO = 1'b0; RESETB = 1'b1; ABORT = 1'b1;
      @(negedge CLK);
      ABORT = 1'b0;
      repeat (3) @(negedge CLK);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
